// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for load data, extracts B/H/W loads, feeds WB and the ID bypass
module mem_stage #(
  parameter int ES_MS_W = 74,
  parameter int MS_WS_W = 70
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               es_to_ms_valid,
  input  logic [ES_MS_W-1:0] es_to_ms_bus,
  output logic               ms_allowin,
  input  logic [31:0]        data_sram_rdata,
  input  logic               data_sram_data_ok,
  input  logic               ws_allowin,
  output logic               ms_to_ws_valid,
  output logic [MS_WS_W-1:0] ms_to_ws_bus,
  output logic [38:0]        ms_to_ds_fwd
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;
  logic [ES_MS_W-1:0] bus_r;
  logic [31:0] buf_r, pc, alu_result, ld_word, ld_data, final_result;
  logic [15:0] ld_half;
  logic [7:0] ld_byte;
  logic [4:0] dest;
  logic [2:0] mem_op;
  logic gr_we, res_from_mem, ms_ready_go, load_pending;
  assign {pc, gr_we, dest, alu_result, res_from_mem, mem_op} = bus_r;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = ms_allowin ? (es_to_ms_valid ? (es_to_ms_bus[3] ? S_WAIT : S_DONE) : S_IDLE)
              : (state == S_WAIT && data_sram_data_ok) ? S_DONE : state;
  end
  always_comb begin
    ms_ready_go    = state == S_DONE || (state == S_WAIT && data_sram_data_ok);
    ms_allowin     = state == S_IDLE || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = state != S_IDLE && ms_ready_go;
    load_pending   = state == S_WAIT && !data_sram_data_ok;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r <= '0;
      buf_r <= '0;
    end else begin
      if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;
      if (state == S_WAIT && data_sram_data_ok) buf_r <= data_sram_rdata;
    end
  end
  always_comb begin
    ld_word      = state == S_WAIT ? data_sram_rdata : buf_r;
    ld_byte      = ld_word[{alu_result[1:0], 3'b000} +: 8];
    ld_half      = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data      = mem_op == 3'b001 ? {{24{ld_byte[7]}}, ld_byte}
                 : mem_op == 3'b101 ? {24'b0, ld_byte}
                 : mem_op == 3'b010 ? {{16{ld_half[15]}}, ld_half}
                 : mem_op == 3'b110 ? {16'b0, ld_half} : ld_word;
    final_result = res_from_mem ? ld_data : alu_result;
  end
  assign ms_to_ws_bus = {pc, gr_we, dest, final_result};
  assign ms_to_ds_fwd = {state != S_IDLE && gr_we, load_pending, dest, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table plus hand sequences for mem_stage, WB outputs checked through a scoreboard queue
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic es_to_ms_valid = 1'b0;
  logic [73:0] es_to_ms_bus = '0;
  logic ms_allowin;
  logic [31:0] data_sram_rdata = '0;
  logic data_sram_data_ok = 1'b0;
  logic ws_allowin = 1'b0;
  logic ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_fwd;
  int checks = 0;
  int errors = 0;
  logic [69:0] q[$];
  logic [69:0] nxt;
  typedef struct {
    logic [2:0]  op;
    logic        rfm;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
    int          wt;
  } vec_t;
  vec_t vt[14];
  always #5 clk = ~clk;
  mem_stage #(.ES_MS_W(74), .MS_WS_W(70)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .ms_allowin(ms_allowin),
    .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ms_to_ds_fwd(ms_to_ds_fwd)
  );
  function automatic logic [73:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic rfm, input logic [2:0] op);
    return {pc, we, d, alu, rfm, op};
  endfunction
  task automatic chk(input string n, input logic [69:0] a, input logic [69:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic tick();
    if (ms_to_ws_valid && ws_allowin) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb got %h want none", ms_to_ws_bus);
      end else chk("wb_bus", ms_to_ws_bus, q.pop_front());
    end
    if (es_to_ms_valid && ms_allowin) q.push_back(nxt);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0]  = '{3'b000, 1'b1, 32'h00000100, 32'hDEADBEEF, 32'hDEADBEEF, 0};
    vt[1]  = '{3'b001, 1'b1, 32'h00000003, 32'h80FF0011, 32'hFFFFFF80, 1};
    vt[2]  = '{3'b001, 1'b1, 32'h00000000, 32'h80FF0011, 32'h00000011, 2};
    vt[3]  = '{3'b001, 1'b1, 32'h00000002, 32'h80FF0011, 32'hFFFFFFFF, 0};
    vt[4]  = '{3'b101, 1'b1, 32'h00000002, 32'h80FF0011, 32'h000000FF, 1};
    vt[5]  = '{3'b101, 1'b1, 32'h00000001, 32'h80FF0011, 32'h00000000, 2};
    vt[6]  = '{3'b010, 1'b1, 32'h00000002, 32'h80FF0011, 32'hFFFF80FF, 0};
    vt[7]  = '{3'b010, 1'b1, 32'h00000000, 32'h12347FFE, 32'h00007FFE, 1};
    vt[8]  = '{3'b110, 1'b1, 32'h00000002, 32'hBEEF1234, 32'h0000BEEF, 2};
    vt[9]  = '{3'b110, 1'b1, 32'h00000001, 32'hBEEF8234, 32'h00008234, 0};
    vt[10] = '{3'b011, 1'b1, 32'h00000001, 32'hCAFEF00D, 32'hCAFEF00D, 1};
    vt[11] = '{3'b111, 1'b1, 32'h00000003, 32'h01234567, 32'h01234567, 2};
    vt[12] = '{3'b001, 1'b0, 32'h87654321, 32'hFFFFFFFF, 32'h87654321, 0};
    vt[13] = '{3'b001, 1'b1, 32'h00000001, 32'h0000A500, 32'hFFFFFFA5, 1};
    #2;
    chk("rst_allowin", 70'(ms_allowin), 70'd1);
    chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rst_bus", ms_to_ws_bus, 70'd0);
    chk("rst_fwd", 70'(ms_to_ds_fwd), 70'd0);
    @(negedge clk);
    resetn = 1'b1;
    ws_allowin = 1'b1;
    nxt = {32'h1C000010, 1'b1, 5'd5, 32'h12345678};
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1C000010, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'b000);
    #1;
    chk("alu_allowin", 70'(ms_allowin), 70'd1);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("alu_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("alu_bus", ms_to_ws_bus, {32'h1C000010, 1'b1, 5'd5, 32'h12345678});
    chk("alu_fwd", 70'(ms_to_ds_fwd), 70'({1'b1, 1'b0, 5'd5, 32'h12345678}));
    tick();
    #1;
    chk("idle_fwd38", 70'(ms_to_ds_fwd[38]), 70'd0);
    tick();
    for (int i = 0; i < 14; i++) begin
      logic [31:0] pc;
      pc = 32'h1C000100 + 32'(i * 4);
      nxt = {pc, 1'b1, 5'(i + 1), vt[i].exp};
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(pc, 1'b1, 5'(i + 1), vt[i].alu, vt[i].rfm, vt[i].op);
      #1;
      chk("vec_allowin", 70'(ms_allowin), 70'd1);
      tick();
      es_to_ms_valid = 1'b0;
      if (vt[i].rfm) begin
        for (int k = 0; k < vt[i].wt; k++) begin
          data_sram_rdata = $urandom;
          #1;
          chk("vec_pending", 70'(ms_to_ds_fwd[37]), 70'd1);
          chk("vec_wait_valid", 70'(ms_to_ws_valid), 70'd0);
          tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = vt[i].rdata;
      end
      #1;
      chk("vec_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("vec_nopend", 70'(ms_to_ds_fwd[37]), 70'd0);
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = $urandom;
    end
    nxt = {32'h1C000300, 1'b1, 5'd9, 32'h0000BEEF};
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1C000300, 1'b1, 5'd9, 32'h00000002, 1'b1, 3'b110);
    #1;
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    tick();
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBEEF1234;
    #1;
    chk("hold_dok_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("hold_dok_allowin", 70'(ms_allowin), 70'd0);
    tick();
    data_sram_data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_sram_rdata = 32'h5A5A0000 + 32'(k);
      #1;
      chk("hold_result", 70'(ms_to_ws_bus[31:0]), 70'h0000BEEF);
      chk("hold_allowin", 70'(ms_allowin), 70'd0);
      chk("hold_valid", 70'(ms_to_ws_valid), 70'd1);
      tick();
    end
    ws_allowin = 1'b1;
    #1;
    chk("hold_release", 70'(ms_allowin), 70'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] pc;
      pc = 32'h1C000200 + 32'(k * 4);
      nxt = {pc, 1'b1, 5'(k + 10), 32'hA0000000 + 32'(k)};
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk(pc, 1'b1, 5'(k + 10), 32'hA0000000 + 32'(k), 1'b0, 3'b000);
      #1;
      chk("b2b_allowin", 70'(ms_allowin), 70'd1);
      chk("b2b_valid", 70'(ms_to_ws_valid), 70'(k > 0));
      tick();
    end
    es_to_ms_valid = 1'b0;
    #1;
    chk("b2b_last_valid", 70'(ms_to_ws_valid), 70'd1);
    tick();
    nxt = {32'h1C000400, 1'b1, 5'd3, 32'h00000000};
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1C000400, 1'b1, 5'd3, 32'h00000000, 1'b1, 3'b000);
    #1;
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("rw_pending", 70'(ms_to_ds_fwd[37]), 70'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rw_allowin", 70'(ms_allowin), 70'd1);
    chk("rw_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rw_fwd", 70'(ms_to_ds_fwd), 70'd0);
    chk("rw_bus", ms_to_ws_bus, 70'd0);
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11223344;
    #1;
    chk("rw_stray_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rw_stray_allowin", 70'(ms_allowin), 70'd1);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk("rw_after_valid", 70'(ms_to_ws_valid), 70'd0);
    tick();
    nxt = {32'h1C000500, 1'b1, 5'd7, 32'hA5A5A5A5};
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1C000500, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 3'b001);
    #1;
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray_result", 70'(ms_to_ws_bus[31:0]), 70'hA5A5A5A5);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h00000000;
    #1;
    chk("stray_hold", 70'(ms_to_ws_bus[31:0]), 70'hA5A5A5A5);
    chk("stray_valid", 70'(ms_to_ws_valid), 70'd1);
    tick();
    ws_allowin = 1'b1;
    #1;
    tick();
    #1;
    chk("sb_empty", 70'(q.size()), 70'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
